// File: rtl/case_mul_pipe_sat.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake and optional
// saturation of the product to dout_WIDTH. One operand rank feeds NUM_STAGE result ranks.
module case_mul_pipe_sat #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 8,
   parameter int din1_WIDTH = 5,
   parameter int dout_WIDTH = 8,
   parameter int SAT        = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  din_vld,
   output logic                  din_rdy,
   input  logic                  is_signed,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  dout_vld,
   input  logic                  dout_rdy,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf
);

   localparam int W  = dout_WIDTH;
   localparam int FW = din0_WIDTH + din1_WIDTH;
   // One spare bit keeps unsigned products positive when viewed as signed.
   localparam int XW = (FW + 1 > W + 1) ? FW + 1 : W + 1;

   localparam logic signed [XW-1:0] ONE  = XW'(1);
   localparam logic signed [XW-1:0] SMAX = (ONE <<< (W - 1)) - ONE;
   localparam logic signed [XW-1:0] SMIN = -(ONE <<< (W - 1));
   localparam logic signed [XW-1:0] UMAX = (ONE <<< W) - ONE;

   // ID is an instance tag only.
   if (ID < 0) begin : g_id_tag
   end

   logic                  advance;
   logic                  op_vld;
   logic                  op_sgn;
   logic [din0_WIDTH-1:0] op_a;
   logic [din1_WIDTH-1:0] op_b;

   logic signed [XW-1:0]  ext_a;
   logic signed [XW-1:0]  ext_b;
   logic signed [XW-1:0]  prod;
   logic                  res_ovf;
   logic [W-1:0]          res_val;

   logic [NUM_STAGE-1:0]        stg_vld;
   logic [NUM_STAGE-1:0]        stg_ovf;
   logic [NUM_STAGE-1:0][W-1:0] stg_res;

   assign advance  = ce & (~dout_vld | dout_rdy);
   assign din_rdy  = advance;
   assign dout_vld = stg_vld[NUM_STAGE-1];
   assign dout     = stg_res[NUM_STAGE-1];
   assign ovf      = stg_ovf[NUM_STAGE-1];

   // Multiply and range-check the registered operands in a common signed width.
   always_comb begin
      ext_a   = {{(XW - din0_WIDTH){op_sgn & op_a[din0_WIDTH-1]}}, op_a};
      ext_b   = {{(XW - din1_WIDTH){op_sgn & op_b[din1_WIDTH-1]}}, op_b};
      prod    = ext_a * ext_b;
      res_ovf = op_sgn ? ((prod > SMAX) || (prod < SMIN)) : (prod > UMAX);
      res_val = prod[W-1:0];
      if (res_ovf && (SAT != 0)) begin
         if (!op_sgn)
            res_val = UMAX[W-1:0];
         else if (prod[XW-1])
            res_val = SMIN[W-1:0];
         else
            res_val = SMAX[W-1:0];
      end
   end

   // Whole pipeline moves in lockstep; a stalled output freezes every rank.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_vld  <= 1'b0;
         op_sgn  <= 1'b0;
         op_a    <= '0;
         op_b    <= '0;
         stg_vld <= '0;
         stg_ovf <= '0;
         stg_res <= '0;
      end else if (advance) begin
         op_vld <= din_vld;
         op_sgn <= is_signed;
         op_a   <= din0;
         op_b   <= din1;
         for (int i = NUM_STAGE - 1; i > 0; i--) begin
            stg_vld[i] <= stg_vld[i-1];
            stg_ovf[i] <= stg_ovf[i-1];
            stg_res[i] <= stg_res[i-1];
         end
         stg_vld[0] <= op_vld;
         stg_ovf[0] <= res_ovf & op_vld;
         stg_res[0] <= res_val;
      end
   end

endmodule

// File: tb/tb_case_mul_pipe_sat.sv
// Self-checking bench: a saturating and a wrapping instance share stimulus and are
// compared every cycle against an arithmetic model fed through an ideal delay line.
module tb_case_mul_pipe_sat;

   localparam int NS    = 3;
   localparam int DEPTH = NS + 1;

   logic       clk;
   logic       reset;
   logic       ce;
   logic       dinVld;
   logic       isSigned;
   logic [7:0] din0;
   logic [4:0] din1;
   logic       doutRdy;

   logic       dinRdy, doutVld, ovf;
   logic [7:0] dout;
   logic       dinRdyW, doutVldW, ovfW;
   logic [7:0] doutW;

   int checks = 0;
   int errors = 0;

   // Model delay line: slot DEPTH-1 is what the output should present.
   bit     mVld [DEPTH];
   longint mProd[DEPTH];
   bit     mSgn [DEPTH];

   case_mul_pipe_sat #(.NUM_STAGE(NS), .SAT(1)) dut (
      .clk(clk), .reset(reset), .ce(ce),
      .din_vld(dinVld), .din_rdy(dinRdy), .is_signed(isSigned),
      .din0(din0), .din1(din1),
      .dout_vld(doutVld), .dout_rdy(doutRdy), .dout(dout), .ovf(ovf)
   );

   case_mul_pipe_sat #(.NUM_STAGE(NS), .SAT(0)) dutWrap (
      .clk(clk), .reset(reset), .ce(ce),
      .din_vld(dinVld), .din_rdy(dinRdyW), .is_signed(isSigned),
      .din0(din0), .din1(din1),
      .dout_vld(doutVldW), .dout_rdy(doutRdy), .dout(doutW), .ovf(ovfW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint product(logic [7:0] a, logic [4:0] b, logic s);
      longint x, y;
      if (s) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'(a);
         y = longint'(b);
      end
      return x * y;
   endfunction

   // Returns {ovf, dout} for an 8-bit result.
   function automatic logic [8:0] expected(longint p, bit s, bit sat);
      logic       o;
      logic [7:0] d;
      longint     t;
      if (s) o = (p > 127) || (p < -128);
      else   o = (p > 255);
      t = p;
      if (o && sat) d = s ? ((p < 0) ? 8'h80 : 8'h7F) : 8'hFF;
      else          d = t[7:0];
      return {o, d};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bit modelReady();
      return ce && (!mVld[DEPTH-1] || doutRdy);
   endfunction

   task automatic checkOutput();
      logic [8:0] es, ew;
      chk("din_rdy", dinRdy, modelReady());
      chk("din_rdy_wrap", dinRdyW, modelReady());
      chk("dout_vld", doutVld, mVld[DEPTH-1]);
      chk("dout_vld_wrap", doutVldW, mVld[DEPTH-1]);
      if (mVld[DEPTH-1]) begin
         es = expected(mProd[DEPTH-1], mSgn[DEPTH-1], 1'b1);
         ew = expected(mProd[DEPTH-1], mSgn[DEPTH-1], 1'b0);
         chk("dout", dout, es[7:0]);
         chk("ovf", ovf, es[8]);
         chk("dout_wrap", doutW, ew[7:0]);
         chk("ovf_wrap", ovfW, ew[8]);
      end
   endtask

   task automatic modelEdge();
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mVld[i] = 1'b0;
      end else if (modelReady()) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            mVld[i]  = mVld[i-1];
            mProd[i] = mProd[i-1];
            mSgn[i]  = mSgn[i-1];
         end
         mVld[0]  = dinVld;
         mProd[0] = product(din0, din1, isSigned);
         mSgn[0]  = isSigned;
      end
   endtask

   // Drive one cycle of operands from a falling edge to the next falling edge.
   task automatic applyStimulus(input bit v, input logic [7:0] a, input logic [4:0] b, input bit s);
      dinVld   = v;
      din0     = a;
      din1     = b;
      isSigned = s;
      #1 checkOutput();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 8'h00, 5'h00, 1'b0);
   endtask

   task automatic checkResult(input string tag, input logic [7:0] dSat, input bit o, input logic [7:0] dWrap);
      chk({tag, "_vld"}, doutVld, 1'b1);
      chk({tag, "_dout"}, dout, dSat);
      chk({tag, "_ovf"}, ovf, o);
      chk({tag, "_dout_wrap"}, doutW, dWrap);
      chk({tag, "_ovf_wrap"}, ovfW, o);
   endtask

   initial begin
      int nextOut;
      int k;
      bit accepted;
      for (int i = 0; i < DEPTH; i++) begin
         mVld[i] = 1'b0; mProd[i] = 0; mSgn[i] = 1'b0;
      end
      reset = 1'b1; ce = 1'b1; doutRdy = 1'b1;
      dinVld = 1'b0; din0 = '0; din1 = '0; isSigned = 1'b0;
      @(negedge clk);
      idle();
      idle();
      chk("reset_dout", dout, 8'h00);
      chk("reset_ovf", ovf, 1'b0);
      chk("reset_vld", doutVld, 1'b0);
      reset = 1'b0;

      $display("[TB] single signed transaction");
      applyStimulus(1'b1, 8'd5, 5'h1D, 1'b1);
      idle(); idle();
      chk("t1_early_vld", doutVld, 1'b0);
      idle();
      checkResult("t1", 8'hF1, 1'b0, 8'hF1);
      idle();
      chk("t1_single_pulse", doutVld, 1'b0);
      idle(); idle();

      $display("[TB] signed saturation back to back");
      applyStimulus(1'b1, 8'd100, 5'd3, 1'b1);
      applyStimulus(1'b1, 8'h80, 5'h10, 1'b1);
      applyStimulus(1'b1, 8'h80, 5'd15, 1'b1);
      applyStimulus(1'b1, 8'hF0, 5'd8, 1'b1);
      checkResult("t2a", 8'h7F, 1'b1, 8'h2C);
      idle();
      checkResult("t2b", 8'h7F, 1'b1, 8'h00);
      idle();
      checkResult("t2c", 8'h80, 1'b1, 8'h80);
      idle();
      checkResult("t2d", 8'h80, 1'b0, 8'h80);
      idle(); idle(); idle();

      $display("[TB] unsigned mode");
      applyStimulus(1'b1, 8'd200, 5'h1F, 1'b0);
      applyStimulus(1'b1, 8'd20, 5'd10, 1'b0);
      idle(); idle();
      checkResult("t3a", 8'hFF, 1'b1, 8'h38);
      idle();
      checkResult("t3b", 8'hC8, 1'b0, 8'hC8);
      idle(); idle(); idle();

      $display("[TB] backpressure stream");
      nextOut = 1;
      k = 1;
      for (int c = 1; c <= 30; c++) begin
         doutRdy = !(c >= 4 && c <= 8);
         if (mVld[DEPTH-1] && doutRdy) begin
            chk("bp_order", dout, nextOut);
            nextOut++;
         end
         accepted = modelReady() && (k <= 10);
         applyStimulus(k <= 10, 8'(k), 5'd1, 1'b0);
         if (accepted) k++;
      end
      chk("bp_count", nextOut, 11);
      doutRdy = 1'b1;

      $display("[TB] clock enable freeze");
      for (int c = 0; c < 14; c++) begin
         ce = !(c >= 4 && c <= 7);
         applyStimulus(1'b1, 8'(11 + c), 5'd2, 1'b1);
      end
      ce = 1'b1;
      idle(); idle(); idle(); idle();

      $display("[TB] asynchronous reset with data in flight");
      applyStimulus(1'b1, 8'd9, 5'd2, 1'b0);
      applyStimulus(1'b1, 8'd10, 5'd2, 1'b0);
      applyStimulus(1'b1, 8'd11, 5'd2, 1'b0);
      applyStimulus(1'b1, 8'd12, 5'd2, 1'b0);
      chk("pre_reset_vld", doutVld, 1'b1);
      #2 reset = 1'b1;
      #1 chk("async_reset_vld", doutVld, 1'b0);
      chk("async_reset_vld_wrap", doutVldW, 1'b0);
      for (int i = 0; i < DEPTH; i++) mVld[i] = 1'b0;
      @(negedge clk);
      idle();
      reset = 1'b0;
      applyStimulus(1'b1, 8'd7, 5'd3, 1'b0);
      idle(); idle();
      chk("post_reset_early", doutVld, 1'b0);
      idle();
      checkResult("post_reset", 8'd21, 1'b0, 8'd21);
      idle(); idle(); idle();

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         logic [7:0] a;
         ce      = ($urandom_range(7) != 0);
         doutRdy = ($urandom_range(3) != 0);
         case ($urandom_range(4))
            0:       a = 8'h80;
            1:       a = 8'h7F;
            2:       a = 8'hFF;
            default: a = 8'($urandom);
         endcase
         applyStimulus($urandom_range(3) != 0, a, 5'($urandom), 1'($urandom));
      end
      ce = 1'b1;
      doutRdy = 1'b1;
      for (int c = 0; c < 6; c++) idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
